// File: rtl/vertex_fifo_arbiter_if.sv
// Bus bundle between the vertex producers, the arbiter and the vertex FIFO.
// slave  : the arbiter's view
// master : the producers/FIFO environment's view
interface vertex_fifo_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 104
);

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_fifo_wr;
  logic [DATA_W-1:0]         o_fifo_wdata;
  logic                      i_fifo_afull;
  logic [NUM_REQ-1:0]        o_grant;
  logic                      o_busy;

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_fifo_afull,
    output o_req_ready,
    output o_fifo_wr,
    output o_fifo_wdata,
    output o_grant,
    output o_busy
  );

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_fifo_afull,
    input  o_req_ready,
    input  o_fifo_wr,
    input  o_fifo_wdata,
    input  o_grant,
    input  o_busy
  );

endinterface

// File: rtl/vertex_fifo_arbiter.sv
// vertex_fifo_arbiter: shares one vertex FIFO write port between NUM_REQ
// producers at triangle granularity (a grant lasts exactly three vertices).
// Build option: define VTX_ARB_RR_EN for round-robin arbitration; when it is
// undefined the lowest-index requester wins and no pointer state exists.
module vertex_fifo_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 104
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  vertex_fifo_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   vtx_cnt_q, vtx_cnt_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic [DATA_W-1:0]  fifo_wdata_q, fifo_wdata_d;

  logic [NUM_REQ-1:0] ready_c;
  logic [NUM_REQ-1:0] win_c;
  logic [DATA_W-1:0]  sel_data_c;
  logic               xfer_c;

`ifdef VTX_ARB_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_idx_c;
  logic [IDX_W-1:0]   ptr_next_c;
`endif

  // Only the owner may be ready, and only while the FIFO has room for the
  // write already in flight plus this one.
  always_comb begin
    ready_c = '0;
    if (state_q == ST_GRANT && !bus.i_fifo_afull) begin
      ready_c = grant_q;
    end
  end

  assign xfer_c = |(bus.i_req_valid & ready_c);

  // Route the owner's data slice to the FIFO write register.
  always_comb begin
    sel_data_c = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant_q[k]) begin
        sel_data_c = sel_data_c | bus.i_req_data[k*int'(DATA_W) +: DATA_W];
      end
    end
  end

`ifdef VTX_ARB_RR_EN
  // Round-robin winner: first valid requester at or after the pointer.
  always_comb begin
    logic found;
    int   idx;
    win_c = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= int'(NUM_REQ)) begin
        idx = idx - int'(NUM_REQ);
      end
      if (!found && bus.i_req_valid[IDX_W'(idx)]) begin
        win_c[IDX_W'(idx)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // Encode the current owner and the pointer value that follows it.
  always_comb begin
    owner_idx_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q[i]) begin
        owner_idx_c = IDX_W'(i);
      end
    end
    if (owner_idx_c == IDX_W'(NUM_REQ - 1)) begin
      ptr_next_c = '0;
    end else begin
      ptr_next_c = owner_idx_c + IDX_W'(1);
    end
  end
`else
  // Fixed priority winner: lowest valid index.
  always_comb begin
    logic found;
    win_c = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && bus.i_req_valid[IDX_W'(i)]) begin
        win_c[IDX_W'(i)] = 1'b1;
        found = 1'b1;
      end
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE, count three transfers in GRANT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    vtx_cnt_d    = vtx_cnt_q;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
`ifdef VTX_ARB_RR_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_req_valid) begin
          grant_d   = win_c;
          vtx_cnt_d = '0;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer_c) begin
          fifo_wr_d    = 1'b1;
          fifo_wdata_d = sel_data_c;
          if (vtx_cnt_q == CNT_W'(2)) begin
            grant_d   = '0;
            vtx_cnt_d = '0;
            state_d   = ST_IDLE;
`ifdef VTX_ARB_RR_EN
            ptr_d     = ptr_next_c;
`endif
          end else begin
            vtx_cnt_d = vtx_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset discards any partial triangle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      vtx_cnt_q    <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      vtx_cnt_q    <= vtx_cnt_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
    end
  end

`ifdef VTX_ARB_RR_EN
  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus.o_req_ready  = ready_c;
  assign bus.o_fifo_wr    = fifo_wr_q;
  assign bus.o_fifo_wdata = fifo_wdata_q;
  assign bus.o_grant      = grant_q;
  assign bus.o_busy       = (state_q == ST_GRANT);

endmodule

// File: tb/tb_vertex_fifo_arbiter.sv
// Testbench for vertex_fifo_arbiter. Producer queues feed the bus; every
// FIFO write is popped from an expected-data scoreboard and compared.
// Expectations follow VTX_ARB_RR_EN when it is defined for the build.
module tb_vertex_fifo_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 104;

  logic clk = 1'b0;
  logic rst_n;

  vertex_fifo_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  vertex_fifo_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0]  prod_q [NUM_REQ][$];
  logic [DATA_W-1:0]  exp_q[$];
  logic [NUM_REQ-1:0] en;
  int                 wr_cyc[$];
  int                 checks;
  int                 errors;
  int                 cyc;
  logic               wr_seen;

  function automatic logic [DATA_W-1:0] mk_vtx(input int p, input int n);
    logic [31:0] r;
    r = $urandom;
    return {16'(16'h1000 * p + n), 16'(~n), 8'(p), r, 32'(n * 7 + p)};
  endfunction

  task automatic update_drive();
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (en[k] && prod_q[k].size() != 0) begin
        bus.i_req_valid[k] = 1'b1;
        bus.i_req_data[k*int'(DATA_W) +: DATA_W] = prod_q[k][0];
      end else begin
        bus.i_req_valid[k] = 1'b0;
        bus.i_req_data[k*int'(DATA_W) +: DATA_W] = '0;
      end
    end
  endtask

  // One clock: handshake producers, then scoreboard the FIFO write port.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    logic [DATA_W-1:0]  e;
    acc = bus.i_req_valid & bus.o_req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (acc[k] && prod_q[k].size() != 0) void'(prod_q[k].pop_front());
    end
    update_drive();
    @(negedge clk);
    cyc++;
    wr_seen = bus.o_fifo_wr;
    checks++;
    if ($countones(bus.o_grant) > 1) begin
      errors++;
      $display("FAIL grant_onehot: got %b required at most one bit", bus.o_grant);
    end
    if (bus.o_fifo_wr) begin
      checks++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h required no write", bus.o_fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_fifo_wdata !== e) begin
          errors++;
          $display("FAIL fifo_wdata: got %h required %h", bus.o_fifo_wdata, e);
        end
      end
    end
  endtask

  task automatic drain(input int limit, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending writes required 0", name, exp_q.size());
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) prod_q[k].delete();
    exp_q.delete();
    wr_cyc.delete();
    en = '1;
    bus.i_fifo_afull = 1'b0;
    update_drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (bus.o_grant !== '0) begin errors++; $display("FAIL rst_grant: got %b required 0", bus.o_grant); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", bus.o_busy); end
    if (bus.o_fifo_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b required 0", bus.o_fifo_wr); end
    if (bus.o_fifo_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h required 0", bus.o_fifo_wdata); end
    if (bus.o_req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b required 0", bus.o_req_ready); end
    // A valid seen in IDLE is not accepted, only arbitrated.
    prod_q[2].push_back(mk_vtx(2, 0));
    update_drive();
    #1;
    checks++;
    if (bus.o_req_ready !== '0) begin errors++; $display("FAIL idle_ready: got %b required 0", bus.o_req_ready); end
    tick();
    checks += 2;
    if (bus.o_grant !== 4'b0100) begin errors++; $display("FAIL idle_grant: got %b required 0100", bus.o_grant); end
    if (bus.o_req_ready !== 4'b0100) begin errors++; $display("FAIL grant_ready: got %b required 0100", bus.o_req_ready); end
  endtask

  task automatic test_single_stream();
    int offs [6] = '{2, 3, 4, 6, 7, 8};
    int base;
    logic [DATA_W-1:0] v;
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      v = mk_vtx(0, n);
      prod_q[0].push_back(v);
      exp_q.push_back(v);
    end
    update_drive();
    base = cyc;
    tick();
    checks += 2;
    if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b required 0001", bus.o_grant); end
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", bus.o_busy); end
    drain(30, "single");
    tick();
    tick();
    checks++;
    if (wr_cyc.size() != 6) begin
      errors++;
      $display("FAIL single_wr_count: got %0d required 6", wr_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_cyc[i] - base != offs[i]) begin
          errors++;
          $display("FAIL single_wr_cycle%0d: got %0d required %0d", i, wr_cyc[i] - base, offs[i]);
        end
      end
    end
  endtask

  task automatic test_two_producers();
    logic [DATA_W-1:0] a [6];
    logic [DATA_W-1:0] b [6];
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      a[n] = mk_vtx(0, n);
      b[n] = mk_vtx(1, n);
      prod_q[0].push_back(a[n]);
      prod_q[1].push_back(b[n]);
    end
`ifdef VTX_ARB_RR_EN
    for (int n = 0; n < 3; n++) exp_q.push_back(a[n]);
    for (int n = 0; n < 3; n++) exp_q.push_back(b[n]);
    for (int n = 3; n < 6; n++) exp_q.push_back(a[n]);
    for (int n = 3; n < 6; n++) exp_q.push_back(b[n]);
`else
    for (int n = 0; n < 6; n++) exp_q.push_back(a[n]);
    for (int n = 0; n < 6; n++) exp_q.push_back(b[n]);
`endif
    update_drive();
    drain(60, "two_prod");
  endtask

  task automatic test_afull();
    logic [DATA_W-1:0] v;
    int nw;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      v = mk_vtx(2, n);
      prod_q[2].push_back(v);
      exp_q.push_back(v);
    end
    update_drive();
    tick();
    tick();
    checks++;
    if (wr_seen !== 1'b1) begin errors++; $display("FAIL afull_first_wr: got %b required 1", wr_seen); end
    bus.i_fifo_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks += 2;
      if (bus.o_req_ready !== '0) begin errors++; $display("FAIL afull_ready: got %b required 0", bus.o_req_ready); end
      if (bus.o_grant !== 4'b0100) begin errors++; $display("FAIL afull_grant: got %b required 0100", bus.o_grant); end
      tick();
      checks++;
      if (wr_seen !== 1'b0) begin errors++; $display("FAIL afull_no_wr: got %b required 0", wr_seen); end
    end
    bus.i_fifo_afull = 1'b0;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin errors++; $display("FAIL afull_resume_ready: got %b required 0100", bus.o_req_ready); end
    drain(10, "afull");
    tick();
    tick();
    nw = wr_cyc.size();
    checks++;
    if (nw != 3) begin errors++; $display("FAIL afull_wr_count: got %0d required 3", nw); end
  endtask

  task automatic test_owner_drop();
    logic [DATA_W-1:0] v;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      v = mk_vtx(0, n);
      prod_q[0].push_back(v);
      exp_q.push_back(v);
    end
    for (int n = 0; n < 3; n++) begin
      v = mk_vtx(3, n);
      prod_q[3].push_back(v);
      exp_q.push_back(v);
    end
    update_drive();
    tick();
    checks++;
    if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL drop_grant: got %b required 0001", bus.o_grant); end
    tick();
    tick();
    en[0] = 1'b0;
    update_drive();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 2;
      if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL drop_hold_grant: got %b required 0001", bus.o_grant); end
      if (wr_seen !== 1'b0) begin errors++; $display("FAIL drop_no_wr: got %b required 0", wr_seen); end
    end
    en[0] = 1'b1;
    update_drive();
    drain(20, "drop");
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] v;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      v = mk_vtx(1, n);
      prod_q[1].push_back(v);
      exp_q.push_back(v);
    end
    update_drive();
    drain(20, "mid_pre");
    checks += 2;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", bus.o_busy); end
    if (bus.o_grant !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b required 0010", bus.o_grant); end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.o_grant !== '0) begin errors++; $display("FAIL mid_rst_grant: got %b required 0", bus.o_grant); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", bus.o_busy); end
    if (bus.o_fifo_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_wr: got %b required 0", bus.o_fifo_wr); end
    if (bus.o_fifo_wdata !== '0) begin errors++; $display("FAIL mid_rst_wdata: got %h required 0", bus.o_fifo_wdata); end
    if (bus.o_req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready: got %b required 0", bus.o_req_ready); end
    for (int k = 0; k < int'(NUM_REQ); k++) prod_q[k].delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      v = mk_vtx(1, 8 + n);
      prod_q[1].push_back(v);
      exp_q.push_back(v);
    end
    for (int n = 0; n < 3; n++) begin
      v = mk_vtx(3, 8 + n);
      prod_q[3].push_back(v);
      exp_q.push_back(v);
    end
    update_drive();
    tick();
    checks++;
    if (bus.o_grant !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b required 0010", bus.o_grant); end
    drain(20, "mid_post");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    wr_seen = 1'b0;
    rst_n = 1'b0;
    en = '1;
    bus.i_req_valid = '0;
    bus.i_req_data = '0;
    bus.i_fifo_afull = 1'b0;
    test_reset();
    test_single_stream();
    test_two_producers();
    test_afull();
    test_owner_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vertex_fifo_arbiter.md
# vertex_fifo_arbiter

Shares the single vertex FIFO write port between up to NUM_REQ vertex producers (transform/clip units) so the triangle assembler downstream always pops three consecutive vertices from the same producer. Arbitration is at triangle granularity: once granted, a producer owns the port until exactly three vertices are written. The block sits between the vertex producers and the vertex FIFO feeding the triangle assembler.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 104, vertex word width; packing {x[15:0], y[15:0], z[7:0], u[31:0], v[31:0]}, passed through unmodified
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_REQ  producer k has a vertex on its data slice
- i_req_data  in  NUM_REQ*DATA_W  slice k = bits [k*DATA_W +: DATA_W]
- o_req_ready  out  NUM_REQ  producer k's vertex accepted this cycle when valid&ready
- o_fifo_wr  out  1  FIFO write strobe (registered)
- o_fifo_wdata  out  DATA_W  FIFO write data (registered)
- i_fifo_afull  in  1  FIFO has ≤1 free entry
- o_grant  out  NUM_REQ  one-hot current owner, 0 when idle
- o_busy  out  1  a triangle is in progress

## Operation
- States: IDLE, GRANT.
- IDLE: if any i_req_valid, select winner (see Configuration), load o_grant one-hot, clear vtx_cnt, go GRANT. No vertex accepted in IDLE.
- GRANT: o_req_ready[g] = !i_fifo_afull; all other ready bits 0. Transfer = i_req_valid[g] & o_req_ready[g].
- Each transfer: vtx_cnt increments (2-bit, 0..2); on transfer with vtx_cnt==2, clear o_grant, update priority pointer, go IDLE.
- Owner dropping valid mid-triangle: grant held indefinitely, no timeout; other producers wait.
- i_fifo_afull mid-triangle: ready low, lock held, resume when deasserted; no vertex lost or duplicated.
- Requesters whose valid is low are never granted; valid may change freely while not granted.
- o_busy = (state==GRANT).

## Timing
- Reset (async assert, sync release): state IDLE, o_grant 0, o_req_ready 0, o_fifo_wr 0, o_fifo_wdata 0, o_busy 0, vtx_cnt 0, priority pointer 0.
- o_req_ready is combinational from state, o_grant, i_fifo_afull.
- Valid first seen in IDLE at cycle t → o_grant at t+1, ready high at t+1 (if not afull) → o_fifo_wr/o_fifo_wdata at t+2.
- Write latency one cycle: transfer at cycle n → o_fifo_wr=1 with that data at n+1; o_fifo_wr otherwise 0.
- Throughput: 3 vertices in 3 consecutive cycles, then 1 idle arbitration cycle; 4 cycles/triangle peak.
- afull threshold of 1 covers the single registered write in flight; FIFO never overflows.
- Reset mid-triangle discards the partial grant; FIFO and triangle assembler must be reset in the same domain.

## Configuration
- VTX_ARB_RR_EN defined: round-robin; search starts at pointer, pointer ← winner+1 (mod NUM_REQ) on triangle completion.
- Undefined: fixed priority, lowest index wins; pointer logic removed.

## Test plan
- Single producer 0 streams 6 vertices A..F → two grants to req 0, FIFO sees A..F in order, one idle cycle between C and D.
- Producers 0 and 1 both valid continuously (RR_EN) → FIFO order 0,0,0,1,1,1,0,0,0; without macro → only req 0 served.
- i_fifo_afull raised after first vertex of req 2 for 5 cycles → ready low 5 cycles, then remaining 2 vertices written, no duplicates, grant never changes.
- Owner drops valid after 2 vertices for 10 cycles while req 3 valid → req 3 not granted until owner's third vertex accepted.
- Async reset asserted during GRANT with vtx_cnt=1 → all outputs 0 immediately, IDLE after release, next valid arbitrates from pointer 0.
